tcp_rx_read_scheduler: RTL and testbench

- Parametrised successor to the single-register notification/read-package path in the TCP wrapper.
- Queues TOE RX notifications and forwards each one once to the application metadata stream.
- Converts each notification into one or more read-package requests, split at MAX_CHUNK bytes.
- Gates each request on RX data-FIFO credit, so a request is only issued when its data is guaranteed to fit; requests are never overwritten or lost.

---
 rtl/tcp_rx_pkg.sv | 35 +++
 rtl/tcp_notif_fifo.sv | 53 +++++
 rtl/tcp_rx_read_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_tcp_rx_read_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_rx_pkg.sv
// Shared types and field layout for the TCP RX notification / read-request path.
package tcp_rx_pkg;

    localparam int unsigned NOTIF_W    = 88;
    localparam int unsigned READ_W     = 32;
    localparam int unsigned SESS_LSB   = 0;
    localparam int unsigned LEN_LSB    = 16;
    localparam int unsigned CLOSED_BIT = 80;

    typedef struct packed {
        logic [6:0]  rsvd;
        logic        closed;
        logic [15:0] port;
        logic [31:0] ip;
        logic [15:0] length;
        logic [15:0] session;
    } notif_t;

    typedef struct packed {
        logic [15:0] len;
        logic [15:0] session;
    } read_req_t;

    typedef enum logic [1:0] {
        StIdle,
        StMeta,
        StCalc,
        StIssue
    } rd_state_e;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/tcp_notif_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output.
module tcp_notif_fifo #(
    parameter int unsigned Width = 88,
    parameter int unsigned Depth = 512,
    localparam int unsigned Aw   = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [Width-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [Width-1:0] rd_data,
    output logic [Aw:0]      level
);

    logic [Width-1:0] mem [Depth];
    logic [Aw-1:0]    wr_ptr_q, rd_ptr_q;
    logic [Aw:0]      level_q;
    logic             push, pop;

    assign wr_ready = (level_q != (Aw+1)'(Depth));
    assign rd_valid = (level_q != '0);
    assign rd_data  = mem[rd_ptr_q];
    assign level    = level_q;
    assign push     = wr_valid & wr_ready;
    assign pop      = rd_valid & rd_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + Aw'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + Aw'(1);
            unique case ({push, pop})
                2'b10:   level_q <= level_q + (Aw+1)'(1);
                2'b01:   level_q <= level_q - (Aw+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/tcp_rx_read_scheduler.sv
// Queues TOE RX notifications, forwards metadata, and issues credit-gated read requests.
module tcp_rx_read_scheduler
    import tcp_rx_pkg::*;
#(
    parameter int unsigned DATA_W      = 512,
    parameter int unsigned NOTIF_DEPTH = 512,
    parameter int unsigned MAX_CHUNK   = 1024,
    parameter int unsigned CREDIT_W    = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                s_notif_valid,
    output logic                s_notif_ready,
    input  logic [NOTIF_W-1:0]  s_notif_data,
    output logic                m_meta_valid,
    input  logic                m_meta_ready,
    output logic [NOTIF_W-1:0]  m_meta_data,
    output logic                m_read_valid,
    input  logic                m_read_ready,
    output logic [READ_W-1:0]   m_read_data,
    input  logic [CREDIT_W-1:0] rx_fifo_free,
    input  logic                rx_beat_in,
    output logic [31:0]         stat_split_cnt,
    output logic [31:0]         stat_stall_cnt,
    output logic [31:0]         stat_underflow_cnt,
    output logic [15:0]         stat_q_level
);

    localparam int unsigned BB  = DATA_W / 8;
    localparam int unsigned QAW = $clog2(NOTIF_DEPTH);
    localparam logic [15:0] MaxChunk = 16'(MAX_CHUNK);

    logic               fifo_rd_valid, fifo_rd_ready;
    logic [NOTIF_W-1:0] fifo_rd_data;
    logic [QAW:0]       fifo_level;

    rd_state_e           state_q, state_d;
    notif_t              ntf_q, ntf_d;
    logic [15:0]         sess_q, sess_d;
    logic [15:0]         rem_q, rem_d;
    logic [15:0]         chunk_q, chunk_d;
    logic [CREDIT_W-1:0] beats_q, beats_d;
    logic                skip_q, skip_d;
    logic                hold_q, hold_d;
    logic [CREDIT_W-1:0] reserved_q, reserved_d;
    logic [31:0]         split_q, split_d;
    logic [31:0]         stall_q, stall_d;
    logic [31:0]         under_q, under_d;
    logic                read_hs;
    logic                credit_ok;
    logic [CREDIT_W:0]   credit_need;
    read_req_t           read_req;

    tcp_notif_fifo #(
        .Width (NOTIF_W),
        .Depth (NOTIF_DEPTH)
    ) u_notif_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .wr_valid (s_notif_valid),
        .wr_ready (s_notif_ready),
        .wr_data  (s_notif_data),
        .rd_valid (fifo_rd_valid),
        .rd_ready (fifo_rd_ready),
        .rd_data  (fifo_rd_data),
        .level    (fifo_level)
    );

    // One extra bit so reserved + beats cannot wrap before the compare.
    assign credit_need = {1'b0, reserved_q} + {1'b0, beats_q};
    assign credit_ok   = ({1'b0, rx_fifo_free} >= credit_need);

    always_comb begin
        state_d       = state_q;
        ntf_d         = ntf_q;
        sess_d        = sess_q;
        rem_d         = rem_q;
        chunk_d       = chunk_q;
        beats_d       = beats_q;
        skip_d        = skip_q;
        hold_d        = hold_q;
        fifo_rd_ready = 1'b0;
        m_meta_valid  = 1'b0;
        m_read_valid  = 1'b0;
        read_hs       = 1'b0;

        unique case (state_q)
            StIdle: begin
                fifo_rd_ready = 1'b1;
                if (fifo_rd_valid) begin
                    ntf_d   = notif_t'(fifo_rd_data);
                    sess_d  = fifo_rd_data[SESS_LSB +: 16];
                    rem_d   = fifo_rd_data[LEN_LSB +: 16];
                    skip_d  = fifo_rd_data[CLOSED_BIT] | (fifo_rd_data[LEN_LSB +: 16] == 16'd0);
                    state_d = StMeta;
                end
            end
            StMeta: begin
                m_meta_valid = 1'b1;
                if (m_meta_ready) begin
                    state_d = skip_q ? StIdle : StCalc;
                end
            end
            StCalc: begin
                chunk_d = (rem_q > MaxChunk) ? MaxChunk : rem_q;
                beats_d = CREDIT_W'(ceil_div(32'(chunk_d), BB));
                state_d = StIssue;
            end
            StIssue: begin
                // Once raised, valid is held by hold_q and credit is not re-evaluated.
                m_read_valid = hold_q | credit_ok;
                if (m_read_valid) begin
                    if (m_read_ready) begin
                        read_hs = 1'b1;
                        hold_d  = 1'b0;
                        rem_d   = rem_q - chunk_q;
                        state_d = (rem_q == chunk_q) ? StIdle : StCalc;
                    end else begin
                        hold_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        split_d    = split_q;
        stall_d    = stall_q;
        under_d    = under_q;
        reserved_d = reserved_q;

        if (state_q == StIssue && !m_read_valid) begin
            stall_d = stall_q + 32'd1;
        end
        if (read_hs && rem_q == ntf_q.length && ntf_q.length > MaxChunk) begin
            split_d = split_q + 32'd1;
        end

        unique case ({read_hs, rx_beat_in})
            2'b10: reserved_d = reserved_q + beats_q;
            2'b11: reserved_d = reserved_q + beats_q - CREDIT_W'(1);
            2'b01: begin
                if (reserved_q == '0) begin
                    under_d = under_q + 32'd1;
                end else begin
                    reserved_d = reserved_q - CREDIT_W'(1);
                end
            end
            default: reserved_d = reserved_q;
        endcase
    end

    always_comb begin
        read_req         = '0;
        read_req.len     = chunk_q;
        read_req.session = sess_q;
    end

    assign m_meta_data        = ntf_q;
    assign m_read_data        = read_req;
    assign stat_split_cnt     = split_q;
    assign stat_stall_cnt     = stall_q;
    assign stat_underflow_cnt = under_q;
    assign stat_q_level       = 16'(fifo_level);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= StIdle;
            ntf_q      <= '0;
            sess_q     <= '0;
            rem_q      <= '0;
            chunk_q    <= '0;
            beats_q    <= '0;
            skip_q     <= 1'b0;
            hold_q     <= 1'b0;
            reserved_q <= '0;
            split_q    <= '0;
            stall_q    <= '0;
            under_q    <= '0;
        end else begin
            state_q    <= state_d;
            ntf_q      <= ntf_d;
            sess_q     <= sess_d;
            rem_q      <= rem_d;
            chunk_q    <= chunk_d;
            beats_q    <= beats_d;
            skip_q     <= skip_d;
            hold_q     <= hold_d;
            reserved_q <= reserved_d;
            split_q    <= split_d;
            stall_q    <= stall_d;
            under_q    <= under_d;
        end
    end

endmodule

// File: tb/tb_tcp_rx_read_scheduler.sv
// Directed plus randomized bench for tcp_rx_read_scheduler against a transaction-level model.
module tb_tcp_rx_read_scheduler;
    import tcp_rx_pkg::*;

    localparam int BB   = 64;
    localparam int MAXC = 1024;

    logic        clk = 1'b0;
    logic        rstn;
    logic        s_notif_valid, s_notif_ready;
    logic [87:0] s_notif_data;
    logic        m_meta_valid, m_meta_ready;
    logic [87:0] m_meta_data;
    logic        m_read_valid, m_read_ready;
    logic [31:0] m_read_data;
    logic [15:0] rx_fifo_free;
    logic        rx_beat_in;
    logic [31:0] stat_split_cnt, stat_stall_cnt, stat_underflow_cnt;
    logic [15:0] stat_q_level;

    tcp_rx_read_scheduler dut (
        .clk                (clk),
        .rstn               (rstn),
        .s_notif_valid      (s_notif_valid),
        .s_notif_ready      (s_notif_ready),
        .s_notif_data       (s_notif_data),
        .m_meta_valid       (m_meta_valid),
        .m_meta_ready       (m_meta_ready),
        .m_meta_data        (m_meta_data),
        .m_read_valid       (m_read_valid),
        .m_read_ready       (m_read_ready),
        .m_read_data        (m_read_data),
        .rx_fifo_free       (rx_fifo_free),
        .rx_beat_in         (rx_beat_in),
        .stat_split_cnt     (stat_split_cnt),
        .stat_stall_cnt     (stat_stall_cnt),
        .stat_underflow_cnt (stat_underflow_cnt),
        .stat_q_level       (stat_q_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] req;
        int          beats;
        bit          first_split;
    } exp_read_t;

    int          tests = 0;
    int          fails = 0;
    logic [87:0] meta_q[$];
    exp_read_t   read_q[$];
    int          exp_res, exp_split, exp_under;
    int          n_meta, n_read, n_push;
    bit          prev_rv, prev_hs;
    logic [31:0] prev_data;

    task automatic check(input string tag, input logic [87:0] obs, input logic [87:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [87:0] mk(input int sess, input int len, input bit closed);
        logic [87:0] nd;
        nd = '0;
        nd[63:32] = $urandom;
        nd[79:64] = 16'($urandom);
        nd[SESS_LSB +: 16] = 16'(sess);
        nd[LEN_LSB +: 16] = 16'(len);
        nd[CLOSED_BIT] = closed;
        return nd;
    endfunction

    // Reference: every accepted notification yields one meta beat and, unless closed or empty,
    // a run of reads of at most MAXC bytes each.
    task automatic model_push(input logic [87:0] d);
        int len, rem, c;
        bit first;
        exp_read_t e;
        meta_q.push_back(d);
        len = int'(d[LEN_LSB +: 16]);
        if (!d[CLOSED_BIT] && len != 0) begin
            rem = len;
            first = 1'b1;
            while (rem > 0) begin
                c = (rem > MAXC) ? MAXC : rem;
                e.req = {16'(c), d[SESS_LSB +: 16]};
                e.beats = (c + BB - 1) / BB;
                e.first_split = first && (len > MAXC);
                read_q.push_back(e);
                rem -= c;
                first = 1'b0;
            end
        end
    endtask

    task automatic model_clear();
        meta_q.delete();
        read_q.delete();
        exp_res = 0; exp_split = 0; exp_under = 0;
        prev_rv = 1'b0; prev_hs = 1'b0; prev_data = '0;
    endtask

    // Sample at the falling edge, update the model with what the next rising edge will commit.
    task automatic tick();
        exp_read_t e;
        @(negedge clk);
        if (!rstn) begin
            model_clear();
        end else begin
            check("split_cnt", stat_split_cnt, exp_split);
            check("underflow_cnt", stat_underflow_cnt, exp_under);
            check("reserved", dut.reserved_q, exp_res);
            if (prev_rv && !prev_hs) begin
                check("read_hold_valid", m_read_valid, 1'b1);
                check("read_hold_data", m_read_data, prev_data);
            end else if (m_read_valid && read_q.size() > 0) begin
                check("credit_gate", int'(rx_fifo_free) >= exp_res + read_q[0].beats, 1'b1);
            end
            if (m_meta_valid && m_meta_ready) begin
                n_meta++;
                if (meta_q.size() == 0) check("meta_unexpected", 1'b1, 1'b0);
                else check("meta_data", m_meta_data, meta_q.pop_front());
            end
            if (m_read_valid && m_read_ready) begin
                n_read++;
                if (read_q.size() == 0) begin
                    check("read_unexpected", m_read_data, 32'hx);
                end else begin
                    e = read_q.pop_front();
                    check("read_data", m_read_data, e.req);
                    exp_res += e.beats;
                    if (e.first_split) exp_split++;
                end
            end
            if (rx_beat_in) begin
                if (exp_res > 0) exp_res--;
                else exp_under++;
            end
            if (s_notif_valid && s_notif_ready) begin
                n_push++;
                model_push(s_notif_data);
            end
            prev_rv   = m_read_valid;
            prev_hs   = m_read_valid && m_read_ready;
            prev_data = m_read_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_notif(input logic [87:0] d);
        int start;
        start = n_push;
        s_notif_valid = 1'b1;
        s_notif_data  = d;
        for (int i = 0; i < 2000 && n_push == start; i++) tick();
        s_notif_valid = 1'b0;
        check("push_timeout", n_push != start, 1'b1);
    endtask

    task automatic wait_reads(input int target);
        for (int i = 0; i < 400 && n_read < target; i++) tick();
        check("read_timeout", n_read >= target, 1'b1);
    endtask

    task automatic wait_read_valid();
        for (int i = 0; i < 100 && !m_read_valid; i++) tick();
        check("read_valid_timeout", m_read_valid, 1'b1);
    endtask

    task automatic drain_beats();
        for (int i = 0; i < 2000 && exp_res > 0; i++) begin
            rx_beat_in = 1'b1;
            tick();
        end
        rx_beat_in = 1'b0;
        check("drain_reserved", exp_res, 0);
    endtask

    task automatic drain_all();
        s_notif_valid = 1'b0;
        m_meta_ready  = 1'b1;
        m_read_ready  = 1'b1;
        rx_fifo_free  = 16'hffff;
        for (int i = 0; i < 20000 && (meta_q.size() > 0 || read_q.size() > 0 || exp_res > 0);
             i++) begin
            rx_beat_in = (exp_res > 0);
            tick();
        end
        rx_beat_in = 1'b0;
        check("drain_meta_empty", meta_q.size(), 0);
        check("drain_read_empty", read_q.size(), 0);
    endtask

    initial begin
        int s0, r0, b0, start, reads0;
        model_clear();
        n_meta = 0; n_read = 0; n_push = 0;
        rstn = 1'b0;
        s_notif_valid = 1'b0;
        s_notif_data  = '0;
        m_meta_ready  = 1'b1;
        m_read_ready  = 1'b1;
        rx_fifo_free  = 16'd100;
        rx_beat_in    = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        check("rst_meta_valid", m_meta_valid, 1'b0);
        check("rst_read_valid", m_read_valid, 1'b0);
        check("rst_notif_ready", s_notif_ready, 1'b1);
        check("rst_q_level", stat_q_level, 16'd0);
        check("rst_stall", stat_stall_cnt, 32'd0);

        // Single 300-byte read: 5 beats reserved.
        push_notif(mk(5, 300, 1'b0));
        wait_reads(1);
        check("single_meta_cnt", n_meta, 1);
        check("single_reserved", dut.reserved_q, 16'd5);
        drain_beats();

        // 2500 bytes split 1024/1024/452.
        push_notif(mk(7, 2500, 1'b0));
        wait_reads(n_read + 3);
        tick();
        check("split_cnt_one", stat_split_cnt, 32'd1);
        check("split_reserved", dut.reserved_q, 16'd40);
        drain_beats();

        // Credit stall, then release.
        rx_fifo_free = 16'd10;
        reads0 = n_read;
        push_notif(mk(9, 1024, 1'b0));
        repeat (10) tick();
        s0 = int'(stat_stall_cnt);
        repeat (8) tick();
        check("stall_count", stat_stall_cnt, 32'(s0 + 8));
        check("stall_valid_low", m_read_valid, 1'b0);
        check("stall_no_read", n_read, reads0);
        rx_fifo_free = 16'd16;
        wait_reads(reads0 + 1);
        check("stall_reserved", dut.reserved_q, 16'd16);
        drain_beats();
        tick();
        check("stall_reserved_zero", dut.reserved_q, 16'd0);

        // Beat with nothing reserved.
        rx_beat_in = 1'b1;
        tick();
        rx_beat_in = 1'b0;
        tick();
        check("underflow_one", stat_underflow_cnt, 32'd1);
        check("underflow_res_zero", dut.reserved_q, 16'd0);

        // Closed and zero-length notifications: meta only.
        rx_fifo_free = 16'd100;
        reads0 = n_read;
        start = n_meta;
        push_notif(mk(11, 500, 1'b1));
        push_notif(mk(12, 0, 1'b0));
        for (int i = 0; i < 50 && n_meta < start + 2; i++) tick();
        repeat (4) tick();
        check("meta_only_cnt", n_meta, start + 2);
        check("meta_only_no_read", n_read, reads0);

        // Fill the queue while metadata is back-pressured.
        m_meta_ready  = 1'b0;
        rx_fifo_free  = 16'hffff;
        start = n_push;
        s_notif_valid = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (!s_notif_ready) break;
            s_notif_data = mk(i, 64 + int'($urandom_range(0, 2000)), 1'b0);
            tick();
        end
        s_notif_valid = 1'b0;
        tick();
        check("full_level", stat_q_level, 16'd512);
        check("full_ready_low", s_notif_ready, 1'b0);
        check("full_accepted", n_push - start, 513);

        // Release, then force a read handshake coincident with a data beat.
        m_read_ready = 1'b1;
        m_meta_ready = 1'b1;
        reads0 = n_read;
        wait_reads(reads0 + 1);
        m_read_ready = 1'b0;
        wait_read_valid();
        r0 = exp_res;
        b0 = read_q[0].beats;
        m_read_ready = 1'b1;
        rx_beat_in   = 1'b1;
        tick();
        rx_beat_in = 1'b0;
        check("coincide_reserved", dut.reserved_q, 16'(r0 + b0 - 1));
        drain_all();

        // Randomized traffic with back-pressure and tight credit.
        for (int i = 0; i < 2000; i++) begin
            m_meta_ready  = ($urandom_range(0, 3) != 0);
            m_read_ready  = ($urandom_range(0, 3) != 0);
            rx_fifo_free  = 16'($urandom_range(0, 48));
            rx_beat_in    = (exp_res > 0) && ($urandom_range(0, 1) == 1);
            s_notif_valid = ($urandom_range(0, 2) == 0);
            s_notif_data  = mk(int'($urandom_range(0, 65535)),
                               ($urandom_range(0, 4) == 0) ? 1024 * int'($urandom_range(0, 3))
                                                           : int'($urandom_range(1, 3000)),
                               $urandom_range(0, 7) == 0);
            tick();
        end
        drain_all();

        // Reset while a request is held valid.
        m_read_ready = 1'b0;
        rx_fifo_free = 16'd100;
        push_notif(mk(3, 200, 1'b0));
        wait_read_valid();
        rstn = 1'b0;
        tick();
        check("midrst_read_valid", m_read_valid, 1'b0);
        check("midrst_q_level", stat_q_level, 16'd0);
        check("midrst_split", stat_split_cnt, 32'd0);
        check("midrst_stall", stat_stall_cnt, 32'd0);
        check("midrst_underflow", stat_underflow_cnt, 32'd0);
        check("midrst_reserved", dut.reserved_q, 16'd0);
        rstn = 1'b1;
        m_read_ready = 1'b1;
        repeat (3) tick();
        check("postrst_read_valid", m_read_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
